// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req, m0_we, m0_lock;
    logic [1:0]        m0_size;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt, m0_rvalid, m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req, m1_we, m1_lock;
    logic [1:0]        m1_size;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt, m1_rvalid, m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_wr_en;
    logic [1:0]        mem_data_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_size, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_size, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_err, m1_rdata,
        output mem_wr_en, mem_data_size, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_size, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_err, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_size, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_err, m1_rdata,
        input  mem_wr_en, mem_data_size, mem_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded burst lock in front of the data memory.
// Rejects illegal size/alignment before memory and returns registered completions.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int             CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic              rr_last_q;

    logic [1:0]              req, we, lock, gnt;
    logic [1:0][1:0]         size;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0][DATA_W-1:0]  wdata;
    logic                    any, win, legal, owner_hit, keep, drive;

    logic [1:0]              rvalid_q, err_q;
    logic [1:0][DATA_W-1:0]  rdata_q;

    assign req   = {bus.m1_req,   bus.m0_req};
    assign we    = {bus.m1_we,    bus.m0_we};
    assign lock  = {bus.m1_lock,  bus.m0_lock};
    assign size  = {bus.m1_size,  bus.m0_size};
    assign addr  = {bus.m1_addr,  bus.m0_addr};
    assign wdata = {bus.m1_wdata, bus.m0_wdata};

    function automatic logic legal_f(input logic [1:0] s, input logic [1:0] a);
        case (s)
            2'b00:   legal_f = 1'b1;
            2'b01:   legal_f = ~a[0];
            2'b10:   legal_f = (a == 2'b00);
            default: legal_f = 1'b0;
        endcase
    endfunction

    // Owner keeps priority; otherwise a tie goes to the port not granted last.
    always_comb begin
        any = 1'b0;
        win = 1'b0;
        if (rst_n && (req != 2'b00)) begin
            any = 1'b1;
            case (state_q)
                OWN0:    win = ~req[0];
                OWN1:    win = req[1];
                default: win = (&req) ? ~rr_last_q : req[1];
            endcase
        end
    end

    assign legal = legal_f(size[win], addr[win][1:0]);
    assign gnt   = {any & win, any & ~win};
    assign drive = any & legal;

    // A non-owner grant out of OWNk always releases, so only owner/FREE wins may lock.
    always_comb begin
        owner_hit = ((state_q == OWN0) && !win) || ((state_q == OWN1) && win);
        burst_d   = (owner_hit ? burst_q : '0) + 1'b1;
        keep      = lock[win] && (owner_hit || (state_q == FREE)) && (burst_d < MAX_C);
    end

    assign bus.m0_gnt        = gnt[0];
    assign bus.m1_gnt        = gnt[1];
    assign bus.mem_wr_en     = drive & we[win];
    assign bus.mem_data_size = drive ? size[win]  : 2'b10;
    assign bus.mem_addr      = drive ? addr[win]  : '0;
    assign bus.mem_wr_data   = drive ? wdata[win] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FREE;
            burst_q   <= '0;
            rr_last_q <= 1'b1;
        end else if (any) begin
            rr_last_q <= win;
            if (keep) begin
                state_q <= win ? OWN1 : OWN0;
                burst_q <= burst_d;
            end else begin
                state_q <= FREE;
                burst_q <= '0;
            end
        end
    end

    // Memory read data only lands in these registers, never on an output directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            for (int k = 0; k < 2; k++) begin
                if (gnt[k]) begin
                    err_q[k]   <= ~legal;
                    rdata_q[k] <= (legal && !we[k]) ? bus.mem_rd_data : '0;
                end
            end
        end
    end

    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-addressed memory model, per-port completion
// scoreboards, and expected grant order written out step by step.
module tb_dmem_arbiter;
    typedef struct {
        logic        req;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } cpl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    cpl_t q0[$];
    cpl_t q1[$];

    logic [7:0]  mem [0:255] = '{default: 8'h00};
    logic [7:0]  ma;
    logic [31:0] rd;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory: little-endian, sign-extending combinational read, write at rising edge.
    assign ma = bus.mem_addr[7:0];
    always_comb begin
        case (bus.mem_data_size)
            2'b00:   rd = {{24{mem[ma][7]}}, mem[ma]};
            2'b01:   rd = {{16{mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
            default: rd = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
        endcase
    end
    assign bus.mem_rd_data = rd;

    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem[ma] <= bus.mem_wr_data[7:0];
            if (bus.mem_data_size != 2'b00) mem[ma+8'd1] <= bus.mem_wr_data[15:8];
            if (bus.mem_data_size == 2'b10) begin
                mem[ma+8'd2] <= bus.mem_wr_data[23:16];
                mem[ma+8'd3] <= bus.mem_wr_data[31:24];
            end
        end
    end

    function automatic beat_t mk(input logic r, input logic w, input logic [1:0] s,
                                 input logic [31:0] a, input logic [31:0] d, input logic l);
        beat_t b;
        b.req = r; b.we = w; b.size = s; b.addr = a; b.wdata = d; b.lock = l;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input beat_t b0, input beat_t b1);
        bus.m0_req = b0.req; bus.m0_we = b0.we; bus.m0_size = b0.size;
        bus.m0_addr = b0.addr; bus.m0_wdata = b0.wdata; bus.m0_lock = b0.lock;
        bus.m1_req = b1.req; bus.m1_we = b1.we; bus.m1_size = b1.size;
        bus.m1_addr = b1.addr; bus.m1_wdata = b1.wdata; bus.m1_lock = b1.lock;
    endtask

    task automatic check_cpl();
        cpl_t c;
        chk("rvalid0", {31'd0, bus.m0_rvalid}, {31'd0, q0.size() != 0});
        if (bus.m0_rvalid && q0.size() != 0) begin
            c = q0.pop_front();
            chk("rdata0", bus.m0_rdata, c.rdata);
            chk("err0", {31'd0, bus.m0_err}, {31'd0, c.err});
        end
        chk("rvalid1", {31'd0, bus.m1_rvalid}, {31'd0, q1.size() != 0});
        if (bus.m1_rvalid && q1.size() != 0) begin
            c = q1.pop_front();
            chk("rdata1", bus.m1_rdata, c.rdata);
            chk("err1", {31'd0, bus.m1_err}, {31'd0, c.err});
        end
    endtask

    // One cycle: drive beats, check last cycle's completions and this cycle's grant.
    task automatic step(input beat_t b0, input beat_t b1, input int win, input logic mwe,
                        input logic [31:0] xrd, input logic xerr);
        cpl_t c;
        apply(b0, b1);
        @(negedge clk);
        check_cpl();
        chk("gnt0", {31'd0, bus.m0_gnt}, {31'd0, win == 0});
        chk("gnt1", {31'd0, bus.m1_gnt}, {31'd0, win == 1});
        chk("mem_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, mwe});
        c.rdata = xrd;
        c.err   = xerr;
        if (win == 0) q0.push_back(c);
        if (win == 1) q1.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input beat_t b0, input beat_t b1);
        apply(b0, b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_gnt0", {31'd0, bus.m0_gnt}, 32'd0);
        chk("rst_gnt1", {31'd0, bus.m1_gnt}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        chk("rst_err", {30'd0, bus.m1_err, bus.m0_err}, 32'd0);
        chk("rst_rdata0", bus.m0_rdata, 32'd0);
        chk("rst_rdata1", bus.m1_rdata, 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        apply(mk(0, 0, 2'b10, 0, 0, 0), mk(0, 0, 2'b10, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    initial begin
        beat_t idle, ld10, lk1, st1;
        idle = mk(0, 0, 2'b10, 32'h0, 32'h0, 1'b0);
        ld10 = mk(1, 0, 2'b10, 32'h10, 32'h0, 1'b0);
        lk1  = mk(1, 0, 2'b10, 32'h10, 32'h0, 1'b1);
        st1  = mk(1, 1, 2'b10, 32'h40, 32'h12345678, 1'b1);
        apply(idle, idle);

        do_reset(ld10, ld10);

        // Single port store then load
        step(mk(1, 1, 2'b10, 32'h10, 32'hDEADBEEF, 0), idle, 0, 1'b1, 32'h0, 1'b0);
        step(ld10, idle, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        step(idle, idle, -1, 1'b0, 32'h0, 1'b0);

        // Contention from reset: 0,1,0,1
        do_reset(idle, idle);
        repeat (2) begin
            step(ld10, ld10, 0, 1'b0, 32'hDEADBEEF, 1'b0);
            step(ld10, ld10, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        end

        // Lock limit with MAX_BURST=4: port 0 first so port 1 wins the tie
        step(ld10, idle, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        repeat (4) step(ld10, lk1, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        step(ld10, lk1, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        step(ld10, lk1, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        step(idle, idle, -1, 1'b0, 32'h0, 1'b0);

        // Misaligned / illegal, then readback of untouched words
        step(mk(1, 1, 2'b01, 32'h3, 32'hAAAA, 0), idle, 0, 1'b0, 32'h0, 1'b1);
        step(mk(1, 0, 2'b10, 32'h6, 32'h0, 0), idle, 0, 1'b0, 32'h0, 1'b1);
        step(mk(1, 1, 2'b11, 32'h0, 32'h55, 0), idle, 0, 1'b0, 32'h0, 1'b1);
        step(mk(1, 0, 2'b10, 32'h0, 32'h0, 0), idle, 0, 1'b0, 32'h0, 1'b0);
        step(mk(1, 0, 2'b10, 32'h4, 32'h0, 0), idle, 0, 1'b0, 32'h0, 1'b0);

        // Sign extension of a byte load
        step(mk(1, 1, 2'b00, 32'h20, 32'h80, 0), idle, 0, 1'b1, 32'h0, 1'b0);
        step(mk(1, 0, 2'b00, 32'h20, 32'h0, 0), idle, 0, 1'b0, 32'hFFFFFF80, 1'b0);
        step(idle, idle, -1, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of a locked port 1 burst with a store pending
        step(idle, lk1, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        step(idle, lk1, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        do_reset(ld10, st1);
        chk("no_write_0x40", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0);
        step(ld10, st1, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        step(idle, st1, 1, 1'b1, 32'h0, 1'b0);
        step(mk(1, 0, 2'b10, 32'h40, 32'h0, 0), idle, 0, 1'b0, 32'h12345678, 1'b0);
        step(idle, idle, -1, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed data memory. It shares the single memory port between the core load/store path (port 0) and a loader/debug DMA master (port 1), with round-robin fairness and a bounded lock for bursts. It rejects misaligned or illegal-size accesses before they reach memory, and returns registered read data and per-beat completion status.

## Interface

Parameters:
- ADDR_W, 32, address width (memory port and requesters)
- DATA_W, 32, data width
- MAX_BURST, 8, maximum consecutive locked grants to one port (≥1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mK_req  in  1  port K request (K = 0, 1)
- mK_we  in  1  1 = store, 0 = load
- mK_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mK_addr  in  ADDR_W  byte address
- mK_wdata  in  DATA_W  store data, right-aligned
- mK_lock  in  1  request to keep ownership after this beat
- mK_gnt  out  1  beat accepted this cycle (combinational)
- mK_rvalid  out  1  one-cycle completion pulse, cycle after grant
- mK_rdata  out  DATA_W  load data, valid with rvalid
- mK_err  out  1  completion was an error, valid with rvalid
- mem_wr_en  out  1  memory write enable
- mem_data_size  out  2  memory access size
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory combinational read data (sign-extended by memory)

## Operation

- A requester holds req/we/size/addr/wdata/lock stable until it sees gnt. It may present the next beat in the cycle after gnt.
- FSM states: FREE, OWN0, OWN1.
  - FREE: a single requester wins. If both request, the port that was not the last granted port wins (rr_last pointer).
  - OWNk: port k has absolute priority. If port k is not requesting, the other port may be granted and the FSM returns to FREE.
- Transitions after a granted beat by port k:
  - lock=1 and burst_cnt+1 < MAX_BURST → OWNk, burst_cnt++.
  - Otherwise → FREE, burst_cnt=0.
- rr_last updates to k on every grant.
- Forced release: when burst_cnt reaches MAX_BURST, the FSM goes to FREE. Since rr_last=k, the other port wins the next tie.
- Legality check:
  - size 11 is an error.
  - size 01 with addr[0]=1 is an error.
  - size 10 with addr[1:0]≠00 is an error.
  - An erroring beat is still granted and still counts for arbitration and lock. mem_wr_en stays 0 for it. The completion reports err=1, rdata=0.
- Memory drive:
  - Granted legal beat: mem_wr_en = we; mem_data_size, mem_addr, mem_wr_data = winner's fields.
  - No grant, or erroring beat: mem_wr_en=0, mem_data_size=10, mem_addr=0, mem_wr_data=0.
- Completion, registered at the edge ending the grant cycle:
  - mK_rvalid=1 for one cycle.
  - Legal load: rdata = mem_rd_data, err=0.
  - Legal store: rdata=0, err=0.
  - Ports not completing: rvalid=0; rdata/err hold their last values.
- Simultaneous requests where the owner drops lock in the same beat: the grant goes to the owner and the FSM goes to FREE.
- Reset, at any time including mid-burst:
  - FSM=FREE, burst_cnt=0, rr_last=1 (port 0 wins the first tie).
  - All rvalid/rdata/err = 0.
  - No memory write occurs while rst_n=0. The gnt outputs are forced to 0.

## Timing

- Grant latency 0: gnt is combinational from req, FSM state and rr_last.
- Stores commit at the rising edge ending the grant cycle.
- Load data latency 1: rvalid and rdata appear in the cycle after gnt.
- Throughput: 1 beat/cycle total, with no bubble on owner switch.
- Worst-case wait for a requesting port: MAX_BURST cycles.
- Combinational paths:
  - req/lock/size/addr → gnt, mem_*.
  - mem_rd_data → rdata register only, so there is no path from mem_rd_data to any output.

## Test plan

- **Single port traffic.** Port 0 stores word 0xDEADBEEF @0x10, then loads word @0x10 → gnt in each request cycle, rvalid the next cycle, rdata=0xDEADBEEF, err=0.
- **Contention and round-robin.** Both ports load every cycle, no lock, starting from reset → grants alternate 0,1,0,1; each rvalid follows its own grant by one cycle.
- **Lock limit.** MAX_BURST=4; port 1 requests with lock=1 continuously while port 0 requests → port 1 gets 4 consecutive grants, port 0 is granted on the 5th cycle, then port 1 again.
- **Misaligned and illegal access.** Port 0 issues half store @0x3, word load @0x6, size 11 @0x0 → all three granted, mem_wr_en=0 throughout, each completes with err=1, rdata=0; memory contents unchanged on readback.
- **Sign extension.** Byte store 0x80 @0x20, then byte load @0x20 → rdata=0xFFFFFF80.
- **Reset mid-burst.** rst_n is asserted low during a locked port 1 burst with a store pending → no write occurs and all rvalid/rdata/err=0. After release, with both ports requesting, port 0 is granted first.
